// File: rtl/spi_master_core.sv
// Byte-oriented SPI master: one byte per chip-select frame, MSB first, full duplex.
// SCK polarity/phase, half-period length and minimum CS-high gap are parameters.
module spi_master_core #(
   parameter int unsigned CLKS_PER_HALF_BIT = 2,
   parameter bit          CPOL              = 1'b0,
   parameter bit          CPHA              = 1'b0,
   parameter int unsigned CS_INACTIVE_CLKS  = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tx_dv_i,
   input  logic [7:0] tx_byte_i,
   output logic       tx_ready_o,
   output logic       rx_dv_o,
   output logic [7:0] rx_byte_o,
   output logic       sck_o,
   output logic       mosi_o,
   input  logic       miso_i,
   output logic       cs_o
);

   localparam int unsigned HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
   localparam int unsigned GW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
   localparam logic [HW-1:0] H_LAST = HW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [GW-1:0] G_LAST = GW'(CS_INACTIVE_CLKS - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StSetup = 3'd1;
   localparam logic [2:0] StXfer  = 3'd2;
   localparam logic [2:0] StHold  = 3'd3;
   localparam logic [2:0] StGap   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic [4:0]    edge_cnt_q, edge_cnt_d;
   logic [7:0]    tx_sr_q, tx_sr_d;
   logic [7:0]    rx_sr_q, rx_sr_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_dv_q, rx_dv_d;
   logic          sck_q, sck_d;
   logic          mosi_q, mosi_d;
   logic          cs_q, cs_d;
   logic          leading;

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      gcnt_d     = gcnt_q;
      edge_cnt_d = edge_cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_byte_d  = rx_byte_q;
      rx_dv_d    = 1'b0;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      cs_d       = cs_q;
      // Edge counter starts at 16, so an even count means the next edge is a leading one.
      leading    = ~edge_cnt_q[0];

      case (state_q)
         StIdle: begin
            if (tx_dv_i) begin
               state_d    = StSetup;
               cs_d       = 1'b0;
               hcnt_d     = H_LAST;
               edge_cnt_d = 5'd16;
               if (CPHA) begin
                  tx_sr_d = tx_byte_i;
                  mosi_d  = 1'b0;
               end else begin
                  tx_sr_d = {tx_byte_i[6:0], 1'b0};
                  mosi_d  = tx_byte_i[7];
               end
            end
         end
         StSetup, StXfer: begin
            if (hcnt_q == '0) begin
               hcnt_d     = H_LAST;
               sck_d      = ~sck_q;
               edge_cnt_d = edge_cnt_q - 5'd1;
               state_d    = (edge_cnt_q == 5'd1) ? StHold : StXfer;
               if (leading ^ CPHA) begin
                  rx_sr_d = {rx_sr_q[6:0], miso_i};
               end else if (edge_cnt_q != 5'd1) begin
                  // Final edge of a CPHA=0 frame is a shift edge with nothing left to shift.
                  mosi_d  = tx_sr_q[7];
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
               end
            end else begin
               hcnt_d = hcnt_q - HW'(1);
            end
         end
         StHold: begin
            if (hcnt_q == '0) begin
               state_d   = StGap;
               cs_d      = 1'b1;
               mosi_d    = 1'b0;
               rx_dv_d   = 1'b1;
               rx_byte_d = rx_sr_q;
               gcnt_d    = G_LAST;
            end else begin
               hcnt_d = hcnt_q - HW'(1);
            end
         end
         StGap: begin
            if (gcnt_q == '0) begin
               state_d = StIdle;
            end else begin
               gcnt_d = gcnt_q - GW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         hcnt_q     <= '0;
         gcnt_q     <= '0;
         edge_cnt_q <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_byte_q  <= '0;
         rx_dv_q    <= 1'b0;
         sck_q      <= CPOL;
         mosi_q     <= 1'b0;
         cs_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         gcnt_q     <= gcnt_d;
         edge_cnt_q <= edge_cnt_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_byte_q  <= rx_byte_d;
         rx_dv_q    <= rx_dv_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         cs_q       <= cs_d;
      end
   end

   assign tx_ready_o = (state_q == StIdle);
   assign rx_dv_o    = rx_dv_q;
   assign rx_byte_o  = rx_byte_q;
   assign sck_o      = sck_q;
   assign mosi_o     = mosi_q;
   assign cs_o       = cs_q;

endmodule
